adder_serial_8bit: RTL and testbench
====================================

ADDER_SERIAL_8BIT -- requirements
Module: adder_serial_8bit

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: start  input  1  request to begin an addition; sampled on rising edge of clk.
REQ-005 Port: in1  input  WIDTH  operand A; sampled only on the edge that accepts start.
REQ-006 Port: in2  input  WIDTH  operand B; sampled only on the edge that accepts start.
REQ-007 Port: busy  output  1  high while an addition is in progress (state RUN).
REQ-008 Port: done  output  1  one-cycle pulse marking a valid new result.
REQ-009 Port: out  output  WIDTH  registered sum of last completed addition.
REQ-010 Port: cout  output  1  registered carry-out of last completed addition.

Function
REQ-011 The block SHALL add in1 and in2 bit-serially, LSB first, one bit per clock, using one carry flip-flop.
REQ-012 FSM states SHALL be IDLE, RUN and DONE only.
REQ-013 IDLE: start=1 SHALL be accepted; operands loaded into internal shift registers, carry cleared, bit counter cleared, next state RUN.
REQ-014 RUN: each cycle, sum bit = a0 XOR b0 XOR carry shifted into result shift register MSB, operands shifted right by one, carry = majority(a0,b0,carry), counter incremented.
REQ-015 RUN: on the edge processing bit WIDTH-1, next state DONE; out and cout SHALL be loaded from the completed result and final carry on that same edge.
REQ-016 Latency: if start is accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH (exactly WIDTH edges after acceptance).
REQ-017 done SHALL be high only in state DONE, for exactly one cycle per accepted start.
REQ-018 DONE: start=1 SHALL be accepted exactly as in IDLE (back-to-back, next state RUN); otherwise next state IDLE.
REQ-019 start during RUN SHALL be ignored; in-progress operands and result SHALL be unaffected.
REQ-020 out and cout SHALL hold their values from the previous completion during RUN and IDLE; partial sums never appear on out.
REQ-021 Sum arithmetic SHALL be modulo 2^WIDTH; cout SHALL be bit WIDTH of the true sum.
REQ-022 busy SHALL be high exactly in state RUN.
REQ-023 Bit counter width SHALL be clog2(WIDTH) bits and SHALL NOT wrap inside a single operation.

Reset
REQ-024 rst=1 at a rising edge SHALL force state IDLE, busy=0, done=0, out=0, cout=0, carry=0, counter=0, shift registers=0.
REQ-025 rst SHALL take priority over start on the same edge; the start is dropped.
REQ-026 rst during RUN SHALL abandon the operation with no done pulse and out/cout cleared to 0.
REQ-027 No asynchronous reset path SHALL exist.

Structure
REQ-028 FSM state encoding and the WIDTH default SHALL live in a shared package (adder_pkg) for reuse by other adder blocks.
REQ-029 The per-bit sum/carry logic SHALL be a separate sub-module adder_fa_1bit (inputs in1, in2, cin; outputs out, cout), instantiated once.
REQ-030 All outputs SHALL be driven directly from flip-flops.

Verification
REQ-031 WIDTH=8, in1=0x0F, in2=0x01, start one cycle in IDLE -> busy high 8 cycles, done pulse 8 edges after acceptance, out=0x10, cout=0.
REQ-032 in1=0xFF, in2=0x01 -> out=0x00, cout=1; in1=0xA5, in2=0x5A -> out=0xFF, cout=0.
REQ-033 start held high with new operands (0x01,0x01) during RUN of 0x0F+0x01 -> ignored; out=0x10, single done pulse.
REQ-034 start with 0x03+0x04 asserted in DONE cycle of previous op -> no IDLE cycle, out=0x07 8 edges later, two done pulses total.
REQ-035 rst=1 at 4th RUN cycle of 0xFF+0xFF -> next cycle busy=0, done=0, out=0x00, cout=0; no done pulse follows.
REQ-036 rst and start high on same edge -> state IDLE, busy stays 0, no done pulse.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the adder family: default operand width, FSM
// state encoding and the majority function used for carry generation.
package adder_pkg;

    localparam int ADDER_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } adder_state_t;

    // Majority of three bits: the carry out of a full adder.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/adder_fa_1bit.sv
// One-bit full adder used as the per-bit datapath of the serial adder.
module adder_fa_1bit
    import adder_pkg::*;
(
    input  logic in1,
    input  logic in2,
    input  logic cin,
    output logic out,
    output logic cout
);

    assign out  = in1 ^ in2 ^ cin;
    assign cout = maj3(in1, in2, cin);

endmodule

// File: rtl/adder_serial_8bit.sv
// Bit-serial adder: operands are captured on start, added LSB first one bit
// per clock through a single full adder and carry flop, and the completed
// sum/carry is published on out/cout together with a one-cycle done pulse.
module adder_serial_8bit
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             cout
);

    // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits never wrap.
    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    adder_state_t     r_state;
    adder_state_t     w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_out;
    logic             r_carry;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;
    logic             w_sum_bit;
    logic             w_carry_next;
    logic             w_accept;
    logic             w_last;

    adder_fa_1bit u_fa (
        .in1  (r_a[0]),
        .in2  (r_b[0]),
        .cin  (r_carry),
        .out  (w_sum_bit),
        .cout (w_carry_next)
    );

    // Next-state decode; start is only honoured from IDLE or DONE.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                    w_accept     = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_next = ST_DONE;
                    w_last       = 1'b1;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                    w_accept     = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Serial datapath: load on accept, shift one bit per RUN cycle, publish on the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= in1;
            r_b     <= in2;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == ST_RUN) begin
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_sum   <= {w_sum_bit, r_sum[WIDTH-1:1]};
            r_carry <= w_carry_next;
            if (w_last) begin
                r_out  <= {w_sum_bit, r_sum[WIDTH-1:1]};
                r_cout <= w_carry_next;
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Status flags registered from the next state so they track RUN/DONE exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_next == ST_RUN);
            r_done <= (w_state_next == ST_DONE);
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign out  = r_out;
    assign cout = r_cout;

endmodule

// File: tb/tb_adder_serial_8bit.sv
// Self-checking bench for adder_serial_8bit (WIDTH=8): directed scenarios with
// literal expectations plus randomized traffic against a transaction model.
module tb_adder_serial_8bit;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] in1   = '0;
    logic [W-1:0] in2   = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] out;
    logic         cout;

    adder_serial_8bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    int total    = 0;
    int bad      = 0;
    bit checking = 1'b0;
    int n_done   = 0;

    // Transaction model: an accepted op lands W edges later as in1+in2.
    logic         m_pend = 1'b0;
    int           m_left = 0;
    logic [W:0]   m_sum  = '0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_out  = '0;
    logic         m_cout = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_pend <= 1'b0;
            m_left <= 0;
            m_done <= 1'b0;
            m_out  <= '0;
            m_cout <= 1'b0;
        end else begin
            m_done <= m_pend && (m_left == 1);
            if (m_pend) begin
                if (m_left == 1) begin
                    m_pend          <= 1'b0;
                    {m_cout, m_out} <= m_sum;
                end
                m_left <= m_left - 1;
            end else if (start) begin
                m_pend <= 1'b1;
                m_left <= W;
                m_sum  <= {1'b0, in1} + {1'b0, in2};
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (checking) begin
            chk("busy", {31'd0, busy}, {31'd0, m_pend});
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("out",  {24'd0, out},  {24'd0, m_out});
            chk("cout", {31'd0, cout}, {31'd0, m_cout});
            if (done === 1'b1) n_done++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start pulse, then wait (bounded) for done; lat=-1 on timeout.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int nbusy);
        start = 1'b1;
        in1   = a;
        in2   = b;
        tick();
        start = 1'b0;
        lat   = -1;
        nbusy = 0;
        if (busy === 1'b1) nbusy++;
        for (int n = 1; n <= W + 4; n++) begin
            tick();
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            if (busy === 1'b1) nbusy++;
        end
    endtask

    int lat;
    int nb;
    int d0;

    initial begin
        tick();
        tick();
        checking = 1'b1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_out",  {24'd0, out},  32'd0);
        rst = 1'b0;
        tick();

        // 0x0F + 0x01
        run_op(8'h0F, 8'h01, lat, nb);
        chk("lat_0f01",  lat, 32'd8);
        chk("busy_cyc",  nb,  32'd8);
        chk("out_0f01",  {24'd0, out}, 32'h10);
        chk("cout_0f01", {31'd0, cout}, 32'd0);
        chk("model_0f01", {23'd0, m_cout, m_out}, 32'h010);
        tick();

        // 0xFF + 0x01 and 0xA5 + 0x5A
        run_op(8'hFF, 8'h01, lat, nb);
        chk("out_ff01",  {24'd0, out},  32'h00);
        chk("cout_ff01", {31'd0, cout}, 32'd1);
        chk("model_ff01", {23'd0, m_cout, m_out}, 32'h100);
        tick();
        run_op(8'hA5, 8'h5A, lat, nb);
        chk("out_a55a",  {24'd0, out},  32'hFF);
        chk("cout_a55a", {31'd0, cout}, 32'd0);
        tick();
        tick();

        // start held high with new operands while running
        d0    = n_done;
        start = 1'b1;
        in1   = 8'h0F;
        in2   = 8'h01;
        tick();
        in1   = 8'h01;
        in2   = 8'h01;
        for (int i = 0; i < 5; i++) tick();
        start = 1'b0;
        lat   = -1;
        for (int n = 6; n <= W + 4; n++) begin
            tick();
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
        chk("lat_held", lat, 32'd8);
        chk("out_held", {24'd0, out}, 32'h10);
        for (int i = 0; i < 4; i++) tick();
        chk("done_cnt_held", n_done - d0, 32'd1);

        // back-to-back: second start issued in the DONE cycle
        d0 = n_done;
        run_op(8'h0F, 8'h01, lat, nb);
        run_op(8'h03, 8'h04, lat, nb);
        chk("lat_b2b",  lat, 32'd8);
        chk("busy_b2b", nb,  32'd8);
        chk("out_b2b",  {24'd0, out}, 32'h07);
        tick();
        chk("done_cnt_b2b", n_done - d0, 32'd2);
        tick();

        // reset in the 4th RUN cycle of 0xFF + 0xFF
        start = 1'b1;
        in1   = 8'hFF;
        in2   = 8'hFF;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d0  = n_done;
        chk("rrun_busy", {31'd0, busy}, 32'd0);
        chk("rrun_done", {31'd0, done}, 32'd0);
        chk("rrun_out",  {24'd0, out},  32'h00);
        chk("rrun_cout", {31'd0, cout}, 32'd0);
        for (int i = 0; i < W + 4; i++) tick();
        chk("rrun_no_done", n_done - d0, 32'd0);

        // reset and start on the same edge
        rst   = 1'b1;
        start = 1'b1;
        in1   = 8'h12;
        in2   = 8'h34;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        d0    = n_done;
        chk("rst_start_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < W + 4; i++) tick();
        chk("rst_start_no_done", n_done - d0, 32'd0);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            rst   = ($urandom_range(0, 59) == 0);
            start = ($urandom_range(0, 2) == 0);
            in1   = 8'($urandom);
            in2   = 8'($urandom);
            tick();
        end
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < W + 4; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
